// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial sequence
// detector. Accepts a WIDTH-bit word over valid/ready and shifts it out one
// bit per clock on x, with gapless back-to-back streaming.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW      = $clog2(WIDTH);
  localparam int OUT_POS = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             on_last;
  logic             accept;

  // Ready is open when idle or while the final bit of the word is on x,
  // which is what lets the next word follow with no gap.
  assign on_last    = (state == SHIFT) && (cnt == '0);
  assign data_ready = !rst && ((state == IDLE) || on_last);
  assign accept     = data_valid && data_ready;

  // Outputs come straight from registered state; nothing here looks at inputs.
  assign x        = (state == SHIFT) ? sr[OUT_POS] : IDLE_LEVEL;
  assign x_valid  = (state == SHIFT);
  assign busy     = (state == SHIFT);
  assign last_bit = on_last;

  // Next-state and datapath: load on accept, otherwise shift toward OUT_POS.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sr_nxt    = data_in;
          cnt_nxt   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sr_nxt  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
          cnt_nxt = cnt - CW'(1);
        end else if (accept) begin
          sr_nxt  = data_in;
          cnt_nxt = CW'(WIDTH - 1);
        end else begin
          state_nxt = IDLE;
          sr_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        sr_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset clears everything and drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: drives an MSB-first and an LSB-first serializer with the
// same inputs and compares every output each cycle against a model that only
// tracks "which word, how many bits left".
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;

  logic rdy [2];
  logic xo  [2];
  logic xv  [2];
  logic lb  [2];
  logic bz  [2];

  int checks = 0;
  int errors = 0;

  // model: bits remaining (0 = idle) and the word being sent, per instance
  int           rem  [2];
  logic [W-1:0] word [2];
  logic         idle_lvl [2];
  logic         msb  [2];

  logic [W-1:0] cap_m, cap_l;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]), .last_bit(lb[0]), .busy(bz[0])
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]), .last_bit(lb[1]), .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: apply inputs, check outputs of the current cycle, then
  // advance the model across the rising edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    logic exp_rdy [2];
    @(negedge clk);
    rst = r; data_valid = v; data_in = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      int   k;
      logic eb;
      k  = W - rem[i];
      eb = (rem[i] > 0) ? (msb[i] ? word[i][W-1-k] : word[i][k]) : idle_lvl[i];
      exp_rdy[i] = !r && (rem[i] <= 1);
      chk($sformatf("x[%0d]", i),          W'(xo[i]),  W'(eb));
      chk($sformatf("x_valid[%0d]", i),    W'(xv[i]),  W'(rem[i] > 0));
      chk($sformatf("busy[%0d]", i),       W'(bz[i]),  W'(rem[i] > 0));
      chk($sformatf("last_bit[%0d]", i),   W'(lb[i]),  W'(rem[i] == 1));
      chk($sformatf("data_ready[%0d]", i), W'(rdy[i]), W'(exp_rdy[i]));
    end
    if (xv[0] === 1'b1) cap_m = {cap_m[W-2:0], xo[0]};
    if (xv[1] === 1'b1) cap_l = {xo[1], cap_l[W-1:1]};
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r)                   rem[i] = 0;
      else if (v && exp_rdy[i]) begin word[i] = d; rem[i] = W; end
      else if (rem[i] > 0)      rem[i] = rem[i] - 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    msb[0] = 1'b1; msb[1] = 1'b0;
    idle_lvl[0] = 1'b0; idle_lvl[1] = 1'b1;
    rem[0] = 0; rem[1] = 0;
    word[0] = '0; word[1] = '0;
    cap_m = '0; cap_l = '0;

    // bring-up reset (state unknown before the first edge, so no checks)
    rst = 1'b1; data_valid = 1'b1; data_in = 8'hFF;
    repeat (2) @(posedge clk);
    // reset held with valid high: ready must stay low, nothing accepted
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    idle(2);

    // single word, then idle return
    step(1'b0, 1'b1, 8'hA5);
    idle(10);

    // back-to-back: valid held, second word taken on the last_bit edge
    step(1'b0, 1'b1, 8'hA5);
    repeat (8) step(1'b0, 1'b1, 8'h3C);
    idle(10);

    // detector feed: MSB-first order of 01101001
    step(1'b0, 1'b1, 8'h69);
    idle(10);
    chk("detector_feed_msb", cap_m, 8'h69);

    // LSB first: 8'h01 -> 1 then seven 0s
    step(1'b0, 1'b1, 8'h01);
    idle(10);
    chk("lsb_word_01", cap_l, 8'h01);

    // reset mid-word with valid held high
    step(1'b0, 1'b1, 8'hFF);
    repeat (3) step(1'b0, 1'b1, 8'hFF);
    repeat (2) step(1'b1, 1'b1, 8'hFF);
    idle(3);

    // stall and input change while busy
    step(1'b0, 1'b1, 8'hF0);
    repeat (8) step(1'b0, 1'b1, 8'h0F);
    idle(10);

    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
